// File: rtl/debug_unlock_ctrl_if.sv
// Request/response bundle between the debug host and the unlock controller.
interface debug_unlock_ctrl_if;
  logic        unlock_req;
  logic [15:0] key_in;
  logic        key_valid;
  logic        relock;
  logic        lock_req;
  logic        debug_unlocked;
  logic        Lock;
  logic        lockout;
  logic [2:0]  fail_count;
  logic        busy;

  modport master (
    output unlock_req, key_in, key_valid, relock, lock_req,
    input  debug_unlocked, Lock, lockout, fail_count, busy
  );

  modport slave (
    input  unlock_req, key_in, key_valid, relock, lock_req,
    output debug_unlocked, Lock, lockout, fail_count, busy
  );
endinterface

// File: rtl/debug_unlock_ctrl.sv
// Debug unlock controller: key challenge with timeout, failure penalty,
// permanent lockout after MAX_FAIL failures, and a lock-set pulse generator.
module debug_unlock_ctrl #(
  parameter logic [15:0] KEY      = 16'hA5C3,
  parameter int          MAX_FAIL = 3,
  parameter int          PENALTY  = 8,
  parameter int          TIMEOUT  = 16
) (
  input  logic              Clk,
  input  logic              resetn,
  debug_unlock_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_KEY, S_CHECK, S_DELAY, S_UNLOCKED, S_LOCKOUT
  } state_t;

  state_t      state, state_next;
  logic [7:0]  timer;
  logic [15:0] key_q;
  logic [2:0]  fail_count;
  logic [2:0]  fc_inc;
  logic        key_match, expire, fail_lock;
  logic        unlocked_d, lockout_d, busy_d, lock_d;
  logic        unlocked_q, lockout_q, busy_q, lock_q;

  // A timer value of 1 means this is the last cycle of the interval, so
  // WAIT_KEY lasts exactly TIMEOUT cycles and DELAY exactly PENALTY cycles.
  assign expire    = (timer == 8'd1);
  assign key_match = (key_q == KEY);
  assign fc_inc    = (fail_count == 3'd7) ? 3'd7 : fail_count + 3'd1;
  assign fail_lock = (fc_inc >= 3'(MAX_FAIL));

  // State register
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic; a key presented on the expiry cycle wins over timeout
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (bus.unlock_req) state_next = S_WAIT_KEY;
      S_WAIT_KEY: begin
        if (bus.key_valid)  state_next = S_CHECK;
        else if (expire)    state_next = fail_lock ? S_LOCKOUT : S_DELAY;
      end
      S_CHECK:    state_next = key_match ? S_UNLOCKED
                             : (fail_lock ? S_LOCKOUT : S_DELAY);
      S_DELAY:    if (expire) state_next = S_IDLE;
      S_UNLOCKED: if (bus.relock) state_next = S_IDLE;
      S_LOCKOUT:  state_next = S_LOCKOUT;
      default:    state_next = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output is a flop
  always_comb begin
    unlocked_d = (state_next == S_UNLOCKED);
    lockout_d  = (state_next == S_LOCKOUT);
    busy_d     = (state_next == S_WAIT_KEY) || (state_next == S_CHECK) ||
                 (state_next == S_DELAY);
    // Both lock sources OR together, so a coincidence is one pulse
    lock_d     = bus.lock_req ||
                 ((state_next == S_LOCKOUT) && (state != S_LOCKOUT));
  end

  // Output registers
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
      busy_q     <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      unlocked_q <= unlocked_d;
      lockout_q  <= lockout_d;
      busy_q     <= busy_d;
      lock_q     <= lock_d;
    end
  end

  // Timer, captured key and failure counter; key is wiped on leaving CHECK
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      timer      <= 8'd0;
      key_q      <= 16'd0;
      fail_count <= 3'd0;
    end else begin
      case (state)
        S_IDLE: if (bus.unlock_req) timer <= 8'(TIMEOUT);
        S_WAIT_KEY: begin
          if (bus.key_valid) begin
            key_q <= bus.key_in;
            timer <= 8'd0;
          end else if (expire) begin
            fail_count <= fc_inc;
            timer      <= fail_lock ? 8'd0 : 8'(PENALTY);
          end else begin
            timer <= timer - 8'd1;
          end
        end
        S_CHECK: begin
          key_q <= 16'd0;
          if (key_match) begin
            fail_count <= 3'd0;
            timer      <= 8'd0;
          end else begin
            fail_count <= fc_inc;
            timer      <= fail_lock ? 8'd0 : 8'(PENALTY);
          end
        end
        S_DELAY: timer <= timer - 8'd1;
        default: ;
      endcase
    end
  end

  assign bus.debug_unlocked = unlocked_q;
  assign bus.lockout        = lockout_q;
  assign bus.busy           = busy_q;
  assign bus.Lock           = lock_q;
  assign bus.fail_count     = fail_count;

endmodule

// File: tb/tb_debug_unlock_ctrl.sv
// Directed bench for debug_unlock_ctrl with default parameters.
module tb_debug_unlock_ctrl;
  localparam logic [15:0] GOOD = 16'hA5C3;

  logic Clk = 1'b0;
  logic resetn = 1'b0;
  int   vec = 0;
  int   errs = 0;

  always #5 Clk = ~Clk;

  debug_unlock_ctrl_if bus();

  debug_unlock_ctrl dut (
    .Clk    (Clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.unlock_req = 1'b0;
    bus.key_in     = 16'h0;
    bus.key_valid  = 1'b0;
    bus.relock     = 1'b0;
    bus.lock_req   = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    tick(); tick();
    vec++; if (bus.debug_unlocked !== 1'b0) begin errs++; $display("FAIL reset_unlocked got %b want 0", bus.debug_unlocked); end
    vec++; if (bus.Lock !== 1'b0) begin errs++; $display("FAIL reset_lock got %b want 0", bus.Lock); end
    vec++; if (bus.lockout !== 1'b0) begin errs++; $display("FAIL reset_lockout got %b want 0", bus.lockout); end
    vec++; if (bus.fail_count !== 3'd0) begin errs++; $display("FAIL reset_fail_count got %0d want 0", bus.fail_count); end
    vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_correct_key();
    bus.unlock_req = 1'b1; tick(); bus.unlock_req = 1'b0;
    vec++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL ck_wait_busy got %b want 1", bus.busy); end
    bus.key_in = GOOD; bus.key_valid = 1'b1; tick(); bus.key_valid = 1'b0; bus.key_in = 16'h0;
    vec++; if (bus.debug_unlocked !== 1'b0 || bus.busy !== 1'b1) begin errs++; $display("FAIL ck_check_cycle got unl=%b busy=%b want 0 1", bus.debug_unlocked, bus.busy); end
    tick();
    vec++; if (bus.debug_unlocked !== 1'b1) begin errs++; $display("FAIL ck_unlocked got %b want 1", bus.debug_unlocked); end
    vec++; if (bus.fail_count !== 3'd0 || bus.busy !== 1'b0) begin errs++; $display("FAIL ck_status got fc=%0d busy=%b want 0 0", bus.fail_count, bus.busy); end
    // unlock_req and key_valid in UNLOCKED are ignored
    bus.unlock_req = 1'b1; bus.key_valid = 1'b1; bus.key_in = 16'h1111; tick(); clear_inputs();
    vec++; if (bus.debug_unlocked !== 1'b1 || bus.busy !== 1'b0) begin errs++; $display("FAIL ck_ignore got unl=%b busy=%b want 1 0", bus.debug_unlocked, bus.busy); end
    bus.relock = 1'b1; tick(); bus.relock = 1'b0;
    vec++; if (bus.debug_unlocked !== 1'b0) begin errs++; $display("FAIL ck_relock got %b want 0", bus.debug_unlocked); end
    tick();
    vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL ck_no_queue got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_lock_req();
    bus.lock_req = 1'b1; tick(); bus.lock_req = 1'b0;
    vec++; if (bus.Lock !== 1'b1) begin errs++; $display("FAIL lr_pulse got %b want 1", bus.Lock); end
    tick();
    vec++; if (bus.Lock !== 1'b0) begin errs++; $display("FAIL lr_pulse_end got %b want 0", bus.Lock); end
    bus.lock_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++; if (bus.Lock !== 1'b1) begin errs++; $display("FAIL lr_held[%0d] got %b want 1", i, bus.Lock); end
    end
    bus.lock_req = 1'b0; tick();
    vec++; if (bus.Lock !== 1'b0 || bus.busy !== 1'b0) begin errs++; $display("FAIL lr_release got lock=%b busy=%b want 0 0", bus.Lock, bus.busy); end
  endtask

  task automatic test_key_at_expiry();
    bus.unlock_req = 1'b1; tick(); bus.unlock_req = 1'b0;
    repeat (15) tick();   // now in the 16th (final) WAIT_KEY cycle
    vec++; if (bus.busy !== 1'b1 || bus.fail_count !== 3'd0) begin errs++; $display("FAIL ke_still_waiting got busy=%b fc=%0d want 1 0", bus.busy, bus.fail_count); end
    bus.key_in = GOOD; bus.key_valid = 1'b1; tick(); bus.key_valid = 1'b0;
    vec++; if (bus.fail_count !== 3'd0 || bus.busy !== 1'b1) begin errs++; $display("FAIL ke_key_wins got fc=%0d busy=%b want 0 1", bus.fail_count, bus.busy); end
    tick();
    vec++; if (bus.debug_unlocked !== 1'b1) begin errs++; $display("FAIL ke_unlocked got %b want 1", bus.debug_unlocked); end
    bus.relock = 1'b1; tick(); bus.relock = 1'b0;
  endtask

  task automatic test_wrong_key();
    int n;
    bus.unlock_req = 1'b1; tick(); bus.unlock_req = 1'b0;
    bus.key_in = 16'h0000; bus.key_valid = 1'b1; tick(); bus.key_valid = 1'b0;
    vec++; if (bus.busy !== 1'b1 || bus.fail_count !== 3'd0) begin errs++; $display("FAIL wk_check got busy=%b fc=%0d want 1 0", bus.busy, bus.fail_count); end
    n = 1;
    for (int i = 0; i < 40; i++) begin
      if (i == 2) begin bus.unlock_req = 1'b1; bus.key_valid = 1'b1; bus.key_in = GOOD; end
      else clear_inputs();
      tick();
      if (i == 0) begin
        vec++; if (bus.fail_count !== 3'd1) begin errs++; $display("FAIL wk_fail_count got %0d want 1", bus.fail_count); end
      end
      if (bus.debug_unlocked !== 1'b0) begin vec++; errs++; $display("FAIL wk_unlock_in_delay got 1 want 0"); end
      if (!bus.busy) break;
      n++;
    end
    clear_inputs();
    vec++; if (n !== 9) begin errs++; $display("FAIL wk_busy_cycles got %0d want 9", n); end
    tick();
    vec++; if (bus.busy !== 1'b0 || bus.debug_unlocked !== 1'b0) begin errs++; $display("FAIL wk_idle got busy=%b unl=%b want 0 0", bus.busy, bus.debug_unlocked); end
  endtask

  task automatic test_timeout();
    int w;
    bus.unlock_req = 1'b1; tick(); bus.unlock_req = 1'b0;
    w = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.debug_unlocked !== 1'b0) begin vec++; errs++; $display("FAIL to_unlocked got 1 want 0"); end
      if (bus.fail_count !== 3'd1) break;
      w++;
    end
    vec++; if (w !== 16) begin errs++; $display("FAIL to_wait_cycles got %0d want 16", w); end
    vec++; if (bus.fail_count !== 3'd2 || bus.busy !== 1'b1 || bus.lockout !== 1'b0) begin errs++; $display("FAIL to_delay got fc=%0d busy=%b lockout=%b want 2 1 0", bus.fail_count, bus.busy, bus.lockout); end
    for (int i = 0; i < 20 && bus.busy; i++) tick();
    vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL to_back_idle got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_lockout();
    bus.unlock_req = 1'b1; tick(); bus.unlock_req = 1'b0;
    bus.key_in = 16'h1234; bus.key_valid = 1'b1; tick(); bus.key_valid = 1'b0;
    // lock_req sampled on the edge that enters LOCKOUT: must merge into one pulse
    bus.lock_req = 1'b1; tick(); bus.lock_req = 1'b0;
    vec++; if (bus.lockout !== 1'b1 || bus.Lock !== 1'b1) begin errs++; $display("FAIL lo_enter got lockout=%b lock=%b want 1 1", bus.lockout, bus.Lock); end
    vec++; if (bus.fail_count !== 3'd3 || bus.busy !== 1'b0) begin errs++; $display("FAIL lo_status got fc=%0d busy=%b want 3 0", bus.fail_count, bus.busy); end
    tick();
    vec++; if (bus.Lock !== 1'b0) begin errs++; $display("FAIL lo_single_pulse got %b want 0", bus.Lock); end
    bus.unlock_req = 1'b1; tick(); bus.unlock_req = 1'b0;
    bus.key_in = GOOD; bus.key_valid = 1'b1; tick(); bus.key_valid = 1'b0;
    tick(); tick();
    vec++; if (bus.debug_unlocked !== 1'b0 || bus.lockout !== 1'b1 || bus.busy !== 1'b0) begin errs++; $display("FAIL lo_terminal got unl=%b lockout=%b busy=%b want 0 1 0", bus.debug_unlocked, bus.lockout, bus.busy); end
  endtask

  task automatic test_reset_mid_ops();
    // out of LOCKOUT, asynchronously
    #2 resetn = 1'b0; #1;
    vec++; if (bus.lockout !== 1'b0 || bus.fail_count !== 3'd0 || bus.Lock !== 1'b0) begin errs++; $display("FAIL rm_lockout_clear got lockout=%b fc=%0d lock=%b want 0 0 0", bus.lockout, bus.fail_count, bus.Lock); end
    tick();
    resetn = 1'b1; bus.unlock_req = 1'b1; tick(); bus.unlock_req = 1'b0;
    vec++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL rm_first_edge got busy=%b want 1", bus.busy); end
    bus.key_in = GOOD; bus.key_valid = 1'b1; tick(); bus.key_valid = 1'b0; tick();
    vec++; if (bus.debug_unlocked !== 1'b1) begin errs++; $display("FAIL rm_unlock got %b want 1", bus.debug_unlocked); end
    // mid-UNLOCKED, checked before the next clock edge
    #2 resetn = 1'b0; #1;
    vec++; if (bus.debug_unlocked !== 1'b0 || bus.busy !== 1'b0 || bus.Lock !== 1'b0) begin errs++; $display("FAIL rm_async_unlock got unl=%b busy=%b lock=%b want 0 0 0", bus.debug_unlocked, bus.busy, bus.Lock); end
    tick(); resetn = 1'b1; tick();
    vec++; if (bus.debug_unlocked !== 1'b0) begin errs++; $display("FAIL rm_no_residue got %b want 0", bus.debug_unlocked); end
    // mid-DELAY
    bus.unlock_req = 1'b1; tick(); bus.unlock_req = 1'b0;
    bus.key_in = 16'hFFFF; bus.key_valid = 1'b1; tick(); bus.key_valid = 1'b0;
    tick(); tick();
    vec++; if (bus.busy !== 1'b1 || bus.fail_count !== 3'd1) begin errs++; $display("FAIL rm_in_delay got busy=%b fc=%0d want 1 1", bus.busy, bus.fail_count); end
    #2 resetn = 1'b0; #1;
    vec++; if (bus.busy !== 1'b0 || bus.fail_count !== 3'd0) begin errs++; $display("FAIL rm_delay_abort got busy=%b fc=%0d want 0 0", bus.busy, bus.fail_count); end
    tick(); resetn = 1'b1; tick();
    vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rm_idle_after got busy=%b want 0", bus.busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_correct_key();
    test_lock_req();
    test_key_at_expiry();
    test_wrong_key();
    test_timeout();
    test_lockout();
    test_reset_mid_ops();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/debug_unlock_ctrl.md
DEBUG_UNLOCK_CTRL -- requirements
Module: debug_unlock_ctrl

Interface
REQ-001 SHALL have parameter KEY, default 16'hA5C3, the debug unlock key.
REQ-002 SHALL have parameter MAX_FAIL, default 3, the number of failed attempts before permanent lockout (range 1..7).
REQ-003 SHALL have parameter PENALTY, default 8, the cycles spent in DELAY after a failed attempt (range 1..255).
REQ-004 SHALL have parameter TIMEOUT, default 16, the cycles allowed in WAIT_KEY before the attempt fails (range 1..255).
REQ-005 SHALL have ports Clk (input, 1, sole clock, rising edge) and resetn (input, 1, asynchronous active-low reset).
REQ-006 SHALL have ports unlock_req (input, 1, start an unlock attempt), key_in (input, 16, candidate key) and key_valid (input, 1, key_in valid this cycle).
REQ-007 SHALL have ports relock (input, 1, leave the debug-unlocked state) and lock_req (input, 1, software request to lock the protected register).
REQ-008 SHALL have output debug_unlocked (1), registered, high only in UNLOCKED; it feeds the downstream register's debug bypass.
REQ-009 SHALL have output Lock (1), registered, a one-cycle pulse that feeds the downstream lock-set input.
REQ-010 SHALL have outputs lockout (1, registered, high in LOCKOUT), fail_count (3, registered, failed attempts) and busy (1, high in WAIT_KEY, CHECK or DELAY).

Function
REQ-011 SHALL implement the states IDLE, WAIT_KEY, CHECK, DELAY, UNLOCKED and LOCKOUT, with one-hot or binary encoding.
REQ-012 IDLE: unlock_req=1 SHALL move to WAIT_KEY next cycle and load the timer with TIMEOUT.
REQ-013 WAIT_KEY: key_valid=1 SHALL capture key_in into a 16-bit register and move to CHECK; otherwise the timer decrements each cycle.
REQ-014 WAIT_KEY: when the timer reaches 0 without key_valid, the attempt SHALL count as a failure, with the same handling as a CHECK mismatch.
REQ-015 WAIT_KEY: if key_valid and timer expiry coincide, the key SHALL take priority.
REQ-016 CHECK (exactly 1 cycle): a captured key equal to KEY SHALL move to UNLOCKED and clear fail_count to 0.
REQ-017 CHECK: on a mismatch, fail_count SHALL increment (saturating at 7).
REQ-018 CHECK: if the new fail_count is >= MAX_FAIL the FSM SHALL move to LOCKOUT; otherwise it SHALL move to DELAY with the timer loaded with PENALTY.
REQ-019 DELAY: the FSM SHALL ignore unlock_req and key_valid and return to IDLE when the timer reaches 0, spending exactly PENALTY cycles in DELAY.
REQ-020 UNLOCKED: debug_unlocked SHALL be 1; relock=1 SHALL return the FSM to IDLE with debug_unlocked=0 the next cycle.
REQ-021 UNLOCKED: unlock_req and key_valid SHALL be ignored.
REQ-022 LOCKOUT SHALL be terminal until resetn is asserted, ignoring all inputs, with debug_unlocked=0.
REQ-023 Lock SHALL pulse high for 1 cycle, 1 cycle after lock_req is sampled high in any state.
REQ-024 Lock SHALL also pulse high for 1 cycle on the cycle the FSM enters LOCKOUT.
REQ-025 Lock SHALL be a single pulse when lock_req and LOCKOUT entry coincide, and SHALL stay high while lock_req is held.
REQ-026 Key latency SHALL be: key_valid accepted at cycle N, then CHECK at N+1, then debug_unlocked=1 at N+2.
REQ-027 The captured key SHALL be cleared to 0 on every exit from CHECK, so no key residue remains.
REQ-028 unlock_req asserted outside IDLE SHALL be ignored and not queued.

Reset
REQ-029 resetn=0 SHALL immediately force the FSM to IDLE.
REQ-030 resetn=0 SHALL immediately force debug_unlocked=0, Lock=0, lockout=0, fail_count=0, busy=0, timer=0 and the captured key to 0.
REQ-031 Reset asserted in any state, including mid-DELAY or UNLOCKED, SHALL abort the operation with no residual unlock.
REQ-032 Release of resetn SHALL be synchronous, with the first state transition possible on the first rising Clk after release.

Verification
REQ-033 Correct key: unlock_req then key_in=16'hA5C3 with key_valid -> debug_unlocked=1 two cycles after key_valid, fail_count=0.
REQ-034 Wrong key: key_in=16'h0000 -> fail_count=1, busy=1 for 1+8 cycles, then IDLE with debug_unlocked=0.
REQ-035 Lockout: three wrong keys -> lockout=1, a single Lock pulse, and later correct keys ignored until resetn.
REQ-036 Timeout: unlock_req with no key_valid for 16 cycles -> fail_count=1, DELAY entered, debug_unlocked never 1.
REQ-037 Relock and lock_req: relock in UNLOCKED -> debug_unlocked=0 next cycle; lock_req=1 for one cycle -> Lock=1 for exactly one cycle.
REQ-038 Reset mid-UNLOCKED: resetn=0 -> debug_unlocked=0 asynchronously, and all outputs at reset values.
